// File: rtl/upsampler_v_0_fp16.sv
// upsampler_v_0_fp16: 2x vertical nearest-neighbour upsampler; each row passes through, then replays from a line buffer
module upsampler_v_0_fp16 #(
  parameter  int EXP_WIDTH    = 5,
  parameter  int FRAC_WIDTH   = 10,
  parameter  int IMG_WIDTH    = 640,
  localparam int FP_WIDTH_REG = 1 + FRAC_WIDTH + EXP_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [FP_WIDTH_REG-1:0] data_i,
  input  logic [15:0]             col_i,
  input  logic [15:0]             row_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [FP_WIDTH_REG-1:0] data_o,
  output logic [15:0]             col_o,
  output logic [15:0]             row_o,
  output logic                    valid_o
);
  localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [15:0] LAST = 16'(IMG_WIDTH - 1);
  typedef enum logic {PASS, REPLAY} state_t;
  state_t r_state, w_next;
  logic [FP_WIDTH_REG-1:0] r_mem [IMG_WIDTH];
  logic [15:0] r_cnt, r_row;
  logic w_acc, w_last, w_cnt_end;
  assign w_acc     = valid_i && ready_o;
  assign w_last    = w_acc && col_i == LAST;
  assign w_cnt_end = r_cnt == LAST;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= PASS;
    else        r_state <= w_next;
  always_comb
    w_next = (r_state == PASS) ? (w_last ? REPLAY : PASS) : (w_cnt_end ? PASS : REPLAY);
  // ready follows reset combinationally so it is low while held and high right after release
  always_comb
    ready_o = rst_i && r_state == PASS;
  always_ff @(posedge clk_i)
    if (w_acc && col_i <= LAST) r_mem[col_i[AW-1:0]] <= data_i;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_cnt   <= '0;
      r_row   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
      col_o   <= '0;
      row_o   <= '0;
    end else begin
      valid_o <= w_acc || r_state == REPLAY;
      if (r_state == REPLAY) begin
        data_o <= r_mem[r_cnt[AW-1:0]];
        col_o  <= r_cnt;
        row_o  <= {r_row[14:0], 1'b1};
        r_cnt  <= w_cnt_end ? '0 : r_cnt + 16'd1;
      end else if (w_acc) begin
        data_o <= data_i;
        col_o  <= col_i;
        row_o  <= {row_i[14:0], 1'b0};
        if (w_last) r_row <= row_i;
      end
    end
endmodule

// File: tb/tb_upsampler_v_0_fp16.sv
// tb_upsampler_v_0_fp16: directed bench for the vertical upsampler with IMG_WIDTH=4
module tb_upsampler_v_0_fp16;
  logic clk_i = 1'b0, rst_i = 1'b0, valid_i = 1'b0;
  logic [15:0] data_i = '0, col_i = '0, row_i = '0;
  logic ready_o, valid_o;
  logic [15:0] data_o, col_o, row_o;
  typedef struct {logic [47:0] v; int cyc;} ent_t;
  ent_t q[$];
  int cyc = 0, low_cnt = 0, n_cmp = 0, n_fail = 0;

  upsampler_v_0_fp16 #(.EXP_WIDTH(5), .FRAC_WIDTH(10), .IMG_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .col_i(col_i), .row_i(row_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .col_o(col_o),
    .row_o(row_o), .valid_o(valid_o));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc = cyc + 1;
  // output monitor: every valid beat as {row,col,data} plus the cycle it was seen
  always @(negedge clk_i) begin
    if (valid_o) q.push_back('{{row_o, col_o, data_o}, cyc});
    if (!ready_o && rst_i) low_cnt = low_cnt + 1;
  end

  task automatic send(input logic [15:0] d, input logic [15:0] c, input logic [15:0] r);
    int n;
    valid_i = 1'b1; data_i = d; col_i = c; row_i = r;
    n = 0;
    while (!ready_o && n < 50) begin @(negedge clk_i); n++; end
    n_cmp++;
    if (n >= 50) begin n_fail++; $display("FAIL send_timeout col=%0d row=%0d ready_o=%b required 1", c, r, ready_o); end
    @(negedge clk_i);
  endtask

  task automatic idle(input int k);
    valid_i = 1'b0;
    repeat (k) @(negedge clk_i);
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", valid_o); end
    n_cmp++; if (data_o !== 16'h0) begin n_fail++; $display("FAIL rst_data got %h want 0000", data_o); end
    n_cmp++; if (col_o !== 16'h0) begin n_fail++; $display("FAIL rst_col got %h want 0000", col_o); end
    n_cmp++; if (row_o !== 16'h0) begin n_fail++; $display("FAIL rst_row got %h want 0000", row_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready_held got %b want 0", ready_o); end
    rst_i = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready_release got %b want 1", ready_o); end
  endtask

  task automatic test_row();
    int c0;
    logic [47:0] e;
    q.delete(); low_cnt = 0; c0 = cyc;
    for (int c = 0; c < 4; c++) send(16'h3C00 + 16'(c), 16'(c), 16'd3);
    idle(8);
    n_cmp++; if (q.size() != 8) begin n_fail++; $display("FAIL row_count got %0d want 8", q.size()); end
    for (int i = 0; i < 8; i++) begin
      e = {16'(i < 4 ? 6 : 7), 16'(i % 4), 16'h3C00 + 16'(i % 4)};
      n_cmp++;
      if (i >= q.size() || q[i].v !== e) begin
        n_fail++; $display("FAIL row_beat%0d got %h want %h", i, (i < q.size()) ? q[i].v : 48'h0, e);
      end
    end
    if (q.size() >= 8) begin
      n_cmp++; if (q[0].cyc != c0 + 1) begin n_fail++; $display("FAIL row_latency got %0d want %0d", q[0].cyc, c0 + 1); end
      n_cmp++; if (q[7].cyc - q[0].cyc != 7) begin n_fail++; $display("FAIL row_contig got %0d want 7", q[7].cyc - q[0].cyc); end
    end
    n_cmp++; if (low_cnt != 4) begin n_fail++; $display("FAIL row_ready_low got %0d want 4", low_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [47:0] e;
    int i;
    q.delete(); low_cnt = 0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) send(16'h1000 + 16'(r * 16 + c), 16'(c), 16'(r));
    idle(12);
    n_cmp++; if (q.size() != 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", q.size()); end
    i = 0;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 4; c++) begin
          e = {16'(2 * r + k), 16'(c), 16'h1000 + 16'(r * 16 + c)};
          n_cmp++;
          if (i >= q.size() || q[i].v !== e) begin
            n_fail++; $display("FAIL b2b_beat%0d got %h want %h", i, (i < q.size()) ? q[i].v : 48'h0, e);
          end
          i++;
        end
    if (q.size() >= 16) begin
      n_cmp++; if (q[15].cyc - q[0].cyc != 15) begin n_fail++; $display("FAIL b2b_contig got %0d want 15", q[15].cyc - q[0].cyc); end
    end
    n_cmp++; if (low_cnt != 8) begin n_fail++; $display("FAIL b2b_ready_low got %0d want 8", low_cnt); end
  endtask

  task automatic test_gap();
    logic [47:0] e;
    q.delete();
    send(16'h2000, 16'd0, 16'd1);
    send(16'h2001, 16'd1, 16'd1);
    idle(3);
    send(16'h2002, 16'd2, 16'd1);
    send(16'h2003, 16'd3, 16'd1);
    idle(8);
    n_cmp++; if (q.size() != 8) begin n_fail++; $display("FAIL gap_count got %0d want 8", q.size()); end
    for (int i = 0; i < 8; i++) begin
      e = {16'(i < 4 ? 2 : 3), 16'(i % 4), 16'h2000 + 16'(i % 4)};
      n_cmp++;
      if (i >= q.size() || q[i].v !== e) begin
        n_fail++; $display("FAIL gap_beat%0d got %h want %h", i, (i < q.size()) ? q[i].v : 48'h0, e);
      end
    end
    if (q.size() >= 8) begin
      n_cmp++; if (q[2].cyc - q[1].cyc != 4) begin n_fail++; $display("FAIL gap_hole got %0d want 4", q[2].cyc - q[1].cyc); end
      n_cmp++; if (q[7].cyc - q[3].cyc != 4) begin n_fail++; $display("FAIL gap_replay_contig got %0d want 4", q[7].cyc - q[3].cyc); end
    end
  endtask

  task automatic test_wrap();
    q.delete();
    for (int c = 0; c < 4; c++) send(16'h4000 + 16'(c), 16'(c), 16'h8001);
    idle(8);
    n_cmp++; if (q.size() != 8) begin n_fail++; $display("FAIL wrap_count got %0d want 8", q.size()); end
    if (q.size() >= 8) begin
      n_cmp++; if (q[0].v[47:32] !== 16'h0002) begin n_fail++; $display("FAIL wrap_pass_row got %h want 0002", q[0].v[47:32]); end
      n_cmp++; if (q[4].v[47:32] !== 16'h0003) begin n_fail++; $display("FAIL wrap_replay_row got %h want 0003", q[4].v[47:32]); end
    end
  endtask

  task automatic test_reset_replay();
    for (int c = 0; c < 4; c++) send(16'h5000 + 16'(c), 16'(c), 16'd2);
    valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rr_valid got %b want 0", valid_o); end
    n_cmp++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rr_ready_held got %b want 0", ready_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rr_ready_release got %b want 1", ready_o); end
    q.delete();
    send(16'h5555, 16'd1, 16'd5);
    idle(8);
    n_cmp++; if (q.size() != 1) begin n_fail++; $display("FAIL rr_count got %0d want 1", q.size()); end
    n_cmp++;
    if (q.size() < 1 || q[0].v !== {16'd10, 16'd1, 16'h5555}) begin
      n_fail++; $display("FAIL rr_beat got %h want %h", (q.size() > 0) ? q[0].v : 48'h0, {16'd10, 16'd1, 16'h5555});
    end
  endtask

  task automatic test_col_oob();
    q.delete(); low_cnt = 0;
    send(16'h6666, 16'd5, 16'd4);
    idle(6);
    n_cmp++; if (q.size() != 1) begin n_fail++; $display("FAIL oob_count got %0d want 1", q.size()); end
    n_cmp++;
    if (q.size() < 1 || q[0].v !== {16'd8, 16'd5, 16'h6666}) begin
      n_fail++; $display("FAIL oob_beat got %h want %h", (q.size() > 0) ? q[0].v : 48'h0, {16'd8, 16'd5, 16'h6666});
    end
    n_cmp++; if (low_cnt != 0) begin n_fail++; $display("FAIL oob_ready_low got %0d want 0", low_cnt); end
  endtask

  initial begin
    test_reset();
    test_row();
    test_back_to_back();
    test_gap();
    test_wrap();
    test_reset_replay();
    test_col_oob();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
